// File: rtl/hazard_controller_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs shared
// between the decode/execute stages and the hazard controller.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic             ex_mem_read;
    logic             ex_wb;
    logic [2:0]       ex_rdst_addr;
    logic [2:0]       id_rsrc_addr;
    logic [2:0]       id_rdst_addr;
    logic             id_uses_rsrc;
    logic             id_uses_rdst;
    logic             id_is_call;
    logic             id_is_ret;
    logic             branch_taken;

    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ie;
    logic             flush_if_id;
    logic             flush_id_ie;
    logic             load_use_case;
    logic             fwd_pc_high_call;
    logic             fwd_pc_low_call;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: supplies decode/execute status, consumes controls.
    modport master (
        output ex_mem_read, ex_wb, ex_rdst_addr, id_rsrc_addr, id_rdst_addr,
               id_uses_rsrc, id_uses_rdst, id_is_call, id_is_ret, branch_taken,
        input  stall_pc, stall_if_id, stall_id_ie, flush_if_id, flush_id_ie,
               load_use_case, fwd_pc_high_call, fwd_pc_low_call, stall_count
    );

    // Controller side.
    modport slave (
        input  ex_mem_read, ex_wb, ex_rdst_addr, id_rsrc_addr, id_rdst_addr,
               id_uses_rsrc, id_uses_rdst, id_is_call, id_is_ret, branch_taken,
        output stall_pc, stall_if_id, stall_id_ie, flush_if_id, flush_id_ie,
               load_use_case, fwd_pc_high_call, fwd_pc_low_call, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Central sequencer for the IF/ID and ID/IE buffers: load-use bubbles,
// two-cycle PC push for CALL, RET fetch freeze, branch flush, and a
// saturating stall-cycle counter.
module hazard_controller #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LDSTALL  = 3'd1,
        CALL_HI  = 3'd2,
        CALL_LO  = 3'd3,
        RET_WAIT = 3'd4
    } state_t;

    // RET_WAIT lasts ret_cnt+1 cycles, so load one less than the bubble count.
    localparam logic [2:0] RET_LOAD = 3'(RET_BUBBLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic lu_hazard;
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ie;
    logic flush_if_id;
    logic flush_id_ie;
    logic load_use_case;
    logic fwd_pc_high_call;
    logic fwd_pc_low_call;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Load-use: a load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_hazard = hz.ex_mem_read & hz.ex_wb &
                    ((hz.id_uses_rsrc & (hz.id_rsrc_addr == hz.ex_rdst_addr)) |
                     (hz.id_uses_rdst & (hz.id_rdst_addr == hz.ex_rdst_addr)));
    end

    // Next-state and control outputs; branch outranks everything, an active
    // CALL/RET sequence outranks new hazards and new CALL/RET decodes.
    always_comb begin
        state_d          = state_q;
        ret_cnt_d        = ret_cnt_q;
        stall_pc         = 1'b0;
        stall_if_id      = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ie      = 1'b0;
        load_use_case    = 1'b0;
        fwd_pc_high_call = 1'b0;
        fwd_pc_low_call  = 1'b0;

        if (hz.branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ie = 1'b1;
            state_d     = IDLE;
            ret_cnt_d   = 3'd0;
        end else begin
            case (state_q)
                CALL_HI: begin
                    stall_pc         = 1'b1;
                    stall_if_id      = 1'b1;
                    fwd_pc_high_call = 1'b1;
                    state_d          = CALL_LO;
                end
                CALL_LO: begin
                    stall_pc        = 1'b1;
                    stall_if_id     = 1'b1;
                    fwd_pc_low_call = 1'b1;
                    flush_if_id     = 1'b1;
                    state_d         = IDLE;
                end
                RET_WAIT: begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    if (ret_cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        ret_cnt_d = ret_cnt_q - 3'd1;
                    end
                end
                default: begin
                    // IDLE and LDSTALL both accept new hazards and decodes;
                    // LDSTALL additionally tells ID/IE the load result is
                    // now forwardable.
                    load_use_case = (state_q == LDSTALL);
                    state_d       = IDLE;
                    if (lu_hazard) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ie = 1'b1;
                        state_d     = LDSTALL;
                    end else if (hz.id_is_call) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        state_d     = CALL_HI;
                    end else if (hz.id_is_ret) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        ret_cnt_d   = RET_LOAD;
                        state_d     = RET_WAIT;
                    end
                end
            endcase
        end

        // ID/IE holds the CALL only while both PC halves are being forwarded.
        stall_id_ie = stall_if_id & ~flush_id_ie &
                      ((state_q == CALL_HI) | (state_q == CALL_LO));

        stall_count_d = stall_pc ? sat_inc(stall_count_q) : stall_count_q;
    end

    // State, RET counter and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ret_cnt_q     <= 3'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ret_cnt_q     <= ret_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.stall_pc         = stall_pc;
    assign hz.stall_if_id      = stall_if_id;
    assign hz.stall_id_ie      = stall_id_ie;
    assign hz.flush_if_id      = flush_if_id;
    assign hz.flush_id_ie      = flush_id_ie;
    assign hz.load_use_case    = load_use_case;
    assign hz.fwd_pc_high_call = fwd_pc_high_call;
    assign hz.fwd_pc_low_call  = fwd_pc_low_call;
    assign hz.stall_count      = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, multi-cycle
// sequences, and random stimulus against a queue-based schedule model.
module tb_hazard_controller;

    localparam int RET_B = 3;
    localparam int CW    = 5;

    // Output word bit positions.
    localparam logic [7:0] SPC = 8'h80;
    localparam logic [7:0] SIF = 8'h40;
    localparam logic [7:0] SIE = 8'h20;
    localparam logic [7:0] FIF = 8'h10;
    localparam logic [7:0] FIE = 8'h08;
    localparam logic [7:0] LUC = 8'h04;
    localparam logic [7:0] FHI = 8'h02;
    localparam logic [7:0] FLO = 8'h01;

    typedef struct {
        logic       mr, wb;
        logic [2:0] rd, rs, rt;
        logic       ur, ut, call, ret, br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        bit         lock;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if #(.CNT_W(CW)) hz ();

    hazard_controller #(.RET_BUBBLES(RET_B), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tab[$];
    rec_t q[$];
    int   mcnt;

    function automatic in_t mk(input int mr, input int wb, input int rd, input int rs,
                               input int rt, input int ur, input int ut, input int call,
                               input int ret, input int br);
        in_t v;
        v.mr = 1'(mr); v.wb = 1'(wb); v.rd = 3'(rd); v.rs = 3'(rs); v.rt = 3'(rt);
        v.ur = 1'(ur); v.ut = 1'(ut); v.call = 1'(call); v.ret = 1'(ret); v.br = 1'(br);
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {hz.stall_pc, hz.stall_if_id, hz.stall_id_ie, hz.flush_if_id,
                hz.flush_id_ie, hz.load_use_case, hz.fwd_pc_high_call, hz.fwd_pc_low_call};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        hz.ex_mem_read  = v.mr;
        hz.ex_wb        = v.wb;
        hz.ex_rdst_addr = v.rd;
        hz.id_rsrc_addr = v.rs;
        hz.id_rdst_addr = v.rt;
        hz.id_uses_rsrc = v.ur;
        hz.id_uses_rdst = v.ut;
        hz.id_is_call   = v.call;
        hz.id_is_ret    = v.ret;
        hz.branch_taken = v.br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges; ends just after an edge.
    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        rst = 1'b0;
        q.delete();
        mcnt = 0;
        tick();
    endtask

    task automatic step(input string nm, input in_t v, input logic [7:0] exp);
        drive(v);
        #1;
        check(nm, 32'(outs()), 32'(exp));
        tick();
    endtask

    task automatic add(input in_t v, input logic [7:0] exp);
        vec_t t;
        t.in  = v;
        t.exp = exp;
        tab.push_back(t);
    endtask

    // Reference model: a queue of pre-scheduled per-cycle output words.
    // Locked entries belong to a CALL/RET sequence and ignore new requests;
    // an unlocked entry is the load-use follow-up cycle, which still admits
    // new requests on top of it.
    function automatic bit is_lu(input in_t v);
        return v.mr && v.wb && ((v.ur && (v.rs == v.rd)) || (v.ut && (v.rt == v.rd)));
    endfunction

    function automatic logic [7:0] model_out(input in_t v);
        logic [7:0] base;
        if (v.br) return FIF | FIE;
        if (q.size() != 0 && q[0].lock) return q[0].o;
        base = (q.size() != 0) ? q[0].o : 8'h00;
        if (is_lu(v)) return base | SPC | SIF | FIE;
        if (v.call || v.ret) return base | SPC | SIF;
        return base;
    endfunction

    task automatic model_commit(input in_t v, input logic [7:0] o);
        rec_t r;
        if ((o & SPC) != 0 && mcnt < (1 << CW) - 1) mcnt++;
        if (v.br) begin
            q.delete();
            return;
        end
        if (q.size() != 0 && q[0].lock) begin
            void'(q.pop_front());
            return;
        end
        if (q.size() != 0) void'(q.pop_front());
        if (is_lu(v)) begin
            r.o = LUC; r.lock = 1'b0; q.push_back(r);
        end else if (v.call) begin
            r.o = SPC | SIF | SIE | FHI; r.lock = 1'b1; q.push_back(r);
            r.o = SPC | SIF | SIE | FLO | FIF; q.push_back(r);
        end else if (v.ret) begin
            for (int k = 0; k < RET_B; k++) begin
                r.o = SPC | FIF; r.lock = 1'b1; q.push_back(r);
            end
        end
    endtask

    initial begin
        in_t idle, lu, call, ret, v;
        logic [7:0] eo;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu   = mk(1, 1, 3, 3, 0, 1, 0, 0, 0, 0);
        call = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        ret  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Single-cycle decisions taken from IDLE.
        add(lu,                                   SPC | SIF | FIE);
        add(mk(1, 1, 3, 4, 0, 1, 0, 0, 0, 0),     8'h00);
        add(mk(1, 0, 3, 3, 0, 1, 0, 0, 0, 0),     8'h00);
        add(mk(0, 1, 3, 3, 0, 1, 0, 0, 0, 0),     8'h00);
        add(mk(1, 1, 5, 0, 5, 0, 1, 0, 0, 0),     SPC | SIF | FIE);
        add(mk(1, 1, 5, 5, 0, 0, 0, 0, 0, 0),     8'h00);
        add(call,                                 SPC | SIF);
        add(ret,                                  SPC | SIF);
        add(mk(1, 1, 3, 3, 0, 1, 0, 1, 0, 0),     SPC | SIF | FIE);
        add(mk(1, 1, 3, 3, 0, 1, 0, 0, 0, 1),     FIF | FIE);
        add(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1),     FIF | FIE);
        add(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),     SPC | SIF);
        add(idle,                                 8'h00);

        // Reset state, including asynchronous assertion before any edge.
        drive(idle);
        rst = 1'b1;
        #1;
        check("rst_outs", 32'(outs()), 32'h0);
        check("rst_cnt", 32'(hz.stall_count), 32'h0);
        #7;
        rst = 1'b0;
        tick();
        check("post_rst_outs", 32'(outs()), 32'h0);

        for (int i = 0; i < tab.size(); i++) begin
            do_reset();
            drive(tab[i].in);
            #1;
            check($sformatf("tab%0d", i), 32'(outs()), 32'(tab[i].exp));
        end

        // Load-use bubble followed by the forwarding cycle.
        do_reset();
        step("lu_c0", lu, SPC | SIF | FIE);
        step("lu_c1", idle, LUC);
        step("lu_c2", idle, 8'h00);
        check("lu_cnt", 32'(hz.stall_count), 32'd1);

        // Non-matching loads never stall.
        do_reset();
        step("nohz_a", mk(1, 1, 3, 4, 0, 1, 0, 0, 0, 0), 8'h00);
        step("nohz_b", mk(1, 0, 3, 3, 0, 1, 0, 0, 0, 0), 8'h00);
        check("nohz_cnt", 32'(hz.stall_count), 32'd0);

        // Back-to-back load-use, then a CALL decoded in LDSTALL.
        do_reset();
        step("b2b_c0", lu, SPC | SIF | FIE);
        step("b2b_c1", lu, LUC | SPC | SIF | FIE);
        step("b2b_c2", call, LUC | SPC | SIF);
        step("b2b_c3", idle, SPC | SIF | SIE | FHI);
        step("b2b_c4", idle, SPC | SIF | SIE | FLO | FIF);
        step("b2b_c5", idle, 8'h00);
        check("b2b_cnt", 32'(hz.stall_count), 32'd5);

        // CALL with the request held: extra decodes are ignored mid-sequence.
        do_reset();
        step("call_c0", call, SPC | SIF);
        step("call_c1", call, SPC | SIF | SIE | FHI);
        step("call_c2", call, SPC | SIF | SIE | FLO | FIF);
        step("call_c3", idle, 8'h00);
        check("call_cnt", 32'(hz.stall_count), 32'd3);

        // RET: detect cycle plus RET_B frozen cycles.
        do_reset();
        step("ret_c0", ret, SPC | SIF);
        for (int k = 1; k <= RET_B; k++) step($sformatf("ret_c%0d", k), ret, SPC | FIF);
        step("ret_end", idle, 8'h00);
        check("ret_cnt", 32'(hz.stall_count), 32'(1 + RET_B));

        // Branch aborts CALL_HI.
        do_reset();
        step("brc_c0", call, SPC | SIF);
        step("brc_c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), FIF | FIE);
        step("brc_c2", idle, 8'h00);
        step("brc_c3", idle, 8'h00);

        // Asynchronous reset while in RET_WAIT.
        do_reset();
        step("arst_c0", ret, SPC | SIF);
        drive(idle);
        #1;
        check("arst_pre", 32'(outs()), 32'(SPC | FIF));
        #1;
        rst = 1'b1;
        #1;
        check("arst_outs", 32'(outs()), 32'h0);
        check("arst_cnt", 32'(hz.stall_count), 32'h0);
        rst = 1'b0;
        tick();
        check("arst_after", 32'(outs()), 32'h0);

        // Counter saturation with a load-use held every cycle.
        do_reset();
        drive(lu);
        for (int k = 0; k < 40; k++) tick();
        check("sat_cnt", 32'(hz.stall_count), 32'((1 << CW) - 1));

        // Random stimulus against the schedule model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            v = mk(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 5) == 0),
                   int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 15) == 0));
            drive(v);
            #1;
            eo = model_out(v);
            check("rand_out", 32'(outs()), 32'(eo));
            check("rand_cnt", 32'(hz.stall_count), 32'(mcnt));
            tick();
            model_commit(v, eo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the IF/ID and ID/IE pipeline buffers.
- Detects load-use hazards, sequences the two-cycle PC push for CALL and the multi-cycle bubble window for RET, and flushes both buffers on a taken branch.
- Drives the ID/IE buffer's stall and flush controls plus its loaduseCase and PC-high/low call-forward inputs.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- RET_BUBBLES, 3, number of cycles fetch is frozen after a RET is decoded (legal range 1..7).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_read  in  1  instruction currently in EX (ID/IE output) is a load.
- ex_wb  in  1  instruction in EX writes back.
- ex_rdst_addr  in  3  destination register of the instruction in EX.
- id_rsrc_addr  in  3  source register of the instruction in ID.
- id_rdst_addr  in  3  second operand register of the instruction in ID.
- id_uses_rsrc  in  1  ID instruction reads rsrc.
- id_uses_rdst  in  1  ID instruction reads rdst.
- id_is_call  in  1  ID holds a CALL.
- id_is_ret  in  1  ID holds a RET.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID buffer.
- stall_id_ie  out  1  hold the ID/IE buffer (stallBuffer).
- flush_if_id  out  1  zero the IF/ID buffer at the next edge.
- flush_id_ie  out  1  zero the ID/IE buffer at the next edge (Flush).
- load_use_case  out  1  drives ID/IE loaduseCase.
- fwd_pc_high_call  out  1  drives ID/IE ForwardPCHighCall.
- fwd_pc_low_call  out  1  drives ID/IE ForwardPCLowCall.
- stall_count  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- State register: IDLE, LDSTALL, CALL_HI, CALL_LO, RET_WAIT. A 3-bit down-counter ret_cnt is used in RET_WAIT.
- All outputs are combinational from state and inputs. State, ret_cnt and stall_count are registered.
- Reset (asynchronous, any cycle, including mid-sequence):
  - state=IDLE, ret_cnt=0, stall_count=0.
  - All single-bit outputs are 0 while rst=1 and in the first cycle after release, unless the inputs trigger a hazard.
- lu_hazard = ex_mem_read & ex_wb & ((id_uses_rsrc & id_rsrc_addr==ex_rdst_addr) | (id_uses_rdst & id_rdst_addr==ex_rdst_addr)).
- Priority per cycle: branch_taken > active sequence (CALL_HI/CALL_LO/RET_WAIT) > lu_hazard > id_is_call > id_is_ret.
- branch_taken=1, any state:
  - flush_if_id=1, flush_id_ie=1; all stall outputs 0.
  - next state IDLE, ret_cnt cleared. Aborts any CALL/RET sequence.
- IDLE:
  - lu_hazard: stall_pc=1, stall_if_id=1, flush_id_ie=1 (bubble); next LDSTALL.
  - id_is_call (no lu_hazard): stall_pc=1, stall_if_id=1; next CALL_HI.
  - id_is_ret (no lu_hazard): stall_pc=1, stall_if_id=1; ret_cnt<=RET_BUBBLES-1; next RET_WAIT.
  - otherwise: all outputs 0.
- LDSTALL: exactly one cycle.
  - load_use_case=1, no stalls; next IDLE.
  - A new lu_hazard in this cycle is handled as in IDLE, so back-to-back stalls are allowed.
- CALL_HI: stall_pc=1, stall_if_id=1, fwd_pc_high_call=1; next CALL_LO.
- CALL_LO: stall_pc=1, stall_if_id=1, fwd_pc_low_call=1, flush_if_id=1; next IDLE.
  - Total CALL cost is 3 stalled cycles, including the detect cycle.
- RET_WAIT: stall_pc=1, flush_if_id=1.
  - Decrement ret_cnt; when ret_cnt==0, next IDLE.
  - Total RET cost is 1+RET_BUBBLES stalled cycles.
- stall_id_ie is asserted only when stall_if_id=1 and flush_id_ie=0 and state is CALL_HI or CALL_LO. The ID/IE buffer holds the CALL while both PC halves are forwarded.
- stall_count increments on every edge where stall_pc=1 and saturates at all-ones. Only reset clears it.
- id_is_call and id_is_ret are sampled only in IDLE and LDSTALL. They are ignored while a sequence is active.

Test Plan:
- Load-use: ex_mem_read=1, ex_wb=1, ex_rdst_addr=3, id_uses_rsrc=1, id_rsrc_addr=3 -> cycle 0: stall_pc=stall_if_id=flush_id_ie=1; cycle 1: load_use_case=1, stalls 0; stall_count=1.
- No hazard: same as above but id_rsrc_addr=4, or ex_wb=0 -> all outputs 0 every cycle, stall_count stays 0.
- CALL: id_is_call pulse in IDLE -> stall_pc high 3 cycles; fwd_pc_high_call in cycle 1, fwd_pc_low_call in cycle 2; stall_id_ie high in cycles 1-2; stall_count=3.
- RET with RET_BUBBLES=3: id_is_ret -> stall_pc high 4 consecutive cycles, flush_if_id high in cycles 1-3, then IDLE.
- Branch mid-CALL: branch_taken=1 during CALL_HI -> same cycle flush_if_id=flush_id_ie=1, fwd_pc_high_call=0; next cycle IDLE with all outputs 0.
- Async reset in RET_WAIT: rst pulse between clock edges -> outputs drop immediately, stall_count=0, and the first post-reset cycle with idle inputs shows all zeros.
